// File: rtl/keypad_scan_if.sv
// Keypad matrix lines plus the decoded-key outputs that feed the history register.
interface keypad_scan_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key;
  logic       key_en;
  logic       key_held;

  modport master (
    input  rows,
    output cols,
    output key,
    output key_en,
    output key_held
  );

  modport slave (
    output rows,
    input  cols,
    input  key,
    input  key_en,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low keypad scanner with press/release debounce and a one-cycle
// strobe per accepted key.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_SCAN     | drive one column low, evaluate rows at end of dwell
// ST_DEBOUNCE | latched row must stay low DEBOUNCE_CYCLES cycles
// ST_EMIT     | one cycle: key updated, key_en high
// ST_HOLD     | key still down, wait for latched row to go high
// ST_RELEASE  | latched row must stay high DEBOUNCE_CYCLES cycles
module keypad_scan_ctrl #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          reset,
  keypad_scan_if.master kp
);

  localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_HOLD,
    ST_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       key_q, key_d;
  logic [3:0]       sync1_q, rows_s_q;

  logic             any_low;
  logic [1:0]       low_idx;
  logic             row_low;
  logic [3:0]       code;

  // Two-flop synchronizer for the asynchronous row lines (idle = all high).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 4'hF;
      rows_s_q <= 4'hF;
    end else begin
      sync1_q  <= kp.rows;
      rows_s_q <= sync1_q;
    end
  end

  // Lowest-index low row wins when several rows are pressed together.
  always_comb begin
    any_low = 1'b0;
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows_s_q[i]) begin
        any_low = 1'b1;
        low_idx = 2'(i);
      end
    end
  end

  assign row_low = ~rows_s_q[row_q];

  // Row/column to hex code; row 3 carries the '*' (E) and '#' (F) keys.
  always_comb begin
    code = 4'h0;
    unique case ({row_q, col_q})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
    endcase
  end

  // Next-state logic; key is loaded on entry to EMIT so it is valid with key_en.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    key_d   = key_q;
    unique case (state_q)
      ST_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (any_low) begin
            row_d   = low_idx;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (!row_low) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
          col_d   = col_q + 2'd1;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_EMIT;
          cnt_d   = '0;
          key_d   = code;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_EMIT: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!row_low) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end
      end
      ST_RELEASE: begin
        if (row_low) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
          col_d   = col_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, latched position and key registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SCAN;
      cnt_q   <= '0;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      key_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      key_q   <= key_d;
    end
  end

  // Outputs decode straight from flops, so reset clears them without waiting for clk.
  assign kp.cols     = ~(4'b0001 << col_q);
  assign kp.key      = key_q;
  assign kp.key_en   = (state_q == ST_EMIT);
  assign kp.key_held = (state_q == ST_EMIT) || (state_q == ST_HOLD) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a simulated key matrix, a cycle-level timeline
// reference, directed scenarios and a randomized press/bounce phase.
module tb_keypad_scan_ctrl;
  localparam int S = 4;
  localparam int D = 8;
  localparam int P_SCAN = 0, P_DEB = 1, P_EMIT = 2, P_HOLD = 3, P_REL = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_scan_if kif ();

  keypad_scan_ctrl #(.SCAN_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif)
  );

  // Physical keys: bit r*4+c is the key at row r, column c.
  logic [15:0] pressed = 16'h0;
  logic [3:0]  rv;
  always_comb begin
    rv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.cols[c]) rv[r] = 1'b0;
  end
  assign kif.rows = rv;

  int n_pass = 0;
  int n_checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return 0;
  endfunction

  // Reference timeline: phase plus the cycle at which the current interval began.
  int         m_phase = P_SCAN;
  int         m_col = 0, m_row = 0, t0 = 0, cyc = 0, mel;
  logic [3:0] m_key = 4'h0, r1 = 4'hF, r2 = 4'hF, mrs;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_phase = P_SCAN; m_col = 0; m_row = 0; m_key = 4'h0;
      r1 = 4'hF; r2 = 4'hF; t0 = cyc;
    end else begin
      mrs = r2; r2 = r1; r1 = kif.rows;
      mel = cyc - t0;
      case (m_phase)
        P_SCAN: if (mel == S-1) begin
          if (mrs != 4'hF) begin m_row = lowest(mrs); m_phase = P_DEB; end
          else m_col = (m_col + 1) % 4;
          t0 = cyc + 1;
        end
        P_DEB: if (mrs[m_row]) begin
          m_phase = P_SCAN; m_col = (m_col + 1) % 4; t0 = cyc + 1;
        end else if (mel == D-1) begin
          m_phase = P_EMIT; m_key = keymap[m_row*4+m_col];
        end
        P_EMIT: m_phase = P_HOLD;
        P_HOLD: if (mrs[m_row]) begin m_phase = P_REL; t0 = cyc + 1; end
        P_REL: if (!mrs[m_row]) m_phase = P_HOLD;
               else if (mel == D-1) begin
                 m_phase = P_SCAN; m_col = (m_col + 1) % 4; t0 = cyc + 1;
               end
        default: m_phase = P_SCAN;
      endcase
      cyc++;
    end
  end

  // Per-cycle comparison against the timeline plus strobe bookkeeping.
  logic [3:0] strobes [$];
  logic       prev_en = 1'b0;
  int         ncyc = 0, last_st = -1;
  logic [3:0] exp_cols;

  initial forever begin
    @(negedge clk);
    ncyc++;
    if (reset) begin
      prev_en = 1'b0; last_st = -1;
    end else begin
      exp_cols = 4'hF;
      exp_cols[m_col] = 1'b0;
      check_val("cols", kif.cols, exp_cols);
      check_val("key", kif.key, m_key);
      check_val("key_en", kif.key_en, m_phase == P_EMIT);
      check_val("key_held", kif.key_held, m_phase == P_EMIT || m_phase == P_HOLD || m_phase == P_REL);
      check_val("en_twice", prev_en && kif.key_en, 0);
      prev_en = kif.key_en;
      if (kif.key_en) begin
        if (last_st >= 0) check_val("strobe_gap", (ncyc - last_st) >= 2*D+3, 1);
        last_st = ncyc;
        strobes.push_back(kif.key);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_held(input int budget);
    for (int i = 0; i < budget && !kif.key_held; i++) @(negedge clk);
    check_val("held_timeout", kif.key_held, 1);
  endtask

  task automatic wait_cols(input logic [3:0] c, input int budget);
    for (int i = 0; i < budget && kif.cols !== c; i++) @(negedge clk);
    check_val("cols_timeout", kif.cols, c);
  endtask

  task automatic bounce(input int idx, input int bursts, input int len);
    for (int b = 0; b < bursts; b++) begin
      pressed[idx] = 1'b1; idle(len);
      pressed[idx] = 1'b0; idle(len);
    end
  endtask

  task automatic expect_strobes(input string tag, input int n, input logic [3:0] last_key);
    check_val({tag, "_count"}, strobes.size(), n);
    if (strobes.size() > 0) check_val({tag, "_key"}, strobes[strobes.size()-1], last_key);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  logic [3:0] ec;
  int         hold_n, k1, k2;

  initial begin
    idle(3);
    reset = 1'b0;

    // Scenario 1: reset in HOLD clears outputs before any clock edge.
    pressed = 16'h0001;
    wait_held(80);
    idle(3);
    check_val("pre_reset_key", kif.key, 4'h1);
    #2 reset = 1'b1;
    #1;
    check_val("rst_cols", kif.cols, 4'hE);
    check_val("rst_key", kif.key, 4'h0);
    check_val("rst_held", kif.key_held, 0);
    check_val("rst_en", kif.key_en, 0);
    pressed = 16'h0;
    idle(3);
    strobes.delete();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ec = 4'hF;
      ec[(i/4)%4] = 1'b0;
      check_val("rotate", kif.cols, ec);
      @(negedge clk);
    end
    expect_strobes("idle", 0, 4'h0);

    // Scenario 2: key '5' for 20 cycles, clean release.
    wait_cols(4'b1101, 20);
    pressed = 16'h0020;
    idle(20);
    pressed = 16'h0;
    idle(30);
    expect_strobes("key5", 1, 4'h5);

    // Scenario 3: bouncing '*' press, then steady.
    strobes.delete();
    bounce(12, 2, 3);
    check_val("bounce_no_strobe", strobes.size(), 0);
    pressed[12] = 1'b1;
    idle(40);
    pressed = 16'h0;
    idle(30);
    expect_strobes("keyE", 1, 4'hE);

    // Scenario 4: long 'A' hold with bouncing release.
    strobes.delete();
    pressed = 16'h0008;
    idle(200);
    for (int b = 0; b < 3; b++) begin
      pressed = 16'h0; idle(3);
      pressed = 16'h0008; idle(3);
    end
    pressed = 16'h0;
    idle(30);
    expect_strobes("keyA", 1, 4'hA);

    // Scenario 5: '7' held, '9' added; '9' reported only after '7' releases.
    strobes.delete();
    pressed = 16'h0100;
    wait_held(80);
    pressed = 16'h0500;
    idle(30);
    check_val("two_key_count", strobes.size(), 1);
    pressed = 16'h0400;
    idle(50);
    pressed = 16'h0;
    idle(30);
    expect_strobes("key9", 2, 4'h9);
    if (strobes.size() > 0) check_val("key7_first", strobes[0], 4'h7);

    // Scenario 6: rows 1 and 3 low on column 1 resolve to row 1.
    strobes.delete();
    pressed = 16'h2020;
    idle(40);
    pressed = 16'h0;
    idle(30);
    expect_strobes("prio", 1, 4'h5);

    // Randomized presses, chords and bounce; the timeline checks every cycle.
    for (int it = 0; it < 30; it++) begin
      k1 = $urandom_range(0, 15);
      k2 = $urandom_range(0, 15);
      hold_n = $urandom_range(0, 50);
      if ($urandom_range(0, 2) == 0) bounce(k1, $urandom_range(1, 3), $urandom_range(1, 4));
      pressed = 16'h0;
      pressed[k1] = 1'b1;
      if ($urandom_range(0, 3) == 0) pressed[k2] = 1'b1;
      idle(hold_n);
      if ($urandom_range(0, 2) == 0) bounce(k1, $urandom_range(1, 3), $urandom_range(1, 4));
      pressed = 16'h0;
      idle($urandom_range(0, 40));
    end

    idle(40);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
